adc_stream_arbiter: RTL



---
 rtl/adc_stream_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/adc_stream_arbiter.sv
// Burst round-robin merge of ADC channel A/B streams onto one AXI-Stream; zero-latency passthrough while granted.
// One idle cycle between bursts; downstream tready is forwarded to the granted source, the other source sees tready=0.
module adc_stream_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  enable,
  input  logic [1:0]            ch_mask,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_chA,
  input  logic                  s_axis_tvalid_chA,
  output logic                  s_axis_tready_chA,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_chB,
  input  logic                  s_axis_tvalid_chB,
  output logic                  s_axis_tready_chB,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  burst_cnt_a,
  output logic [CNT_WIDTH-1:0]  burst_cnt_b
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic                 ptr;  // 0 = channel A has priority at next arbitration
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 cand_a, cand_b;
  logic                 last_beat;
  logic                 beat_done;

  assign cand_a    = enable & ch_mask[0] & s_axis_tvalid_chA;
  assign cand_b    = enable & ch_mask[1] & s_axis_tvalid_chB;
  assign last_beat = (beat_cnt == (len_q - LEN_ONE));

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    m_axis_tdata      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    m_axis_tuser      = 1'b0;
    s_axis_tready_chA = 1'b0;
    s_axis_tready_chB = 1'b0;
    busy              = 1'b0;
    beat_done         = 1'b0;
    case (state)
      IDLE: begin
        if (!ptr) begin
          if (cand_a)      state_nxt = GRANT_A;
          else if (cand_b) state_nxt = GRANT_B;
        end else begin
          if (cand_b)      state_nxt = GRANT_B;
          else if (cand_a) state_nxt = GRANT_A;
        end
      end
      GRANT_A: begin
        busy              = 1'b1;
        m_axis_tdata      = s_axis_tdata_chA;
        m_axis_tvalid     = s_axis_tvalid_chA;
        s_axis_tready_chA = m_axis_tready;
        m_axis_tlast      = last_beat;
        beat_done         = s_axis_tvalid_chA & m_axis_tready;
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      GRANT_B: begin
        busy              = 1'b1;
        m_axis_tdata      = s_axis_tdata_chB;
        m_axis_tvalid     = s_axis_tvalid_chB;
        s_axis_tready_chB = m_axis_tready;
        m_axis_tuser      = 1'b1;
        m_axis_tlast      = last_beat;
        beat_done         = s_axis_tvalid_chB & m_axis_tready;
        if (beat_done && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length is captured only at grant so a running burst is never truncated.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      ptr         <= 1'b0;
      beat_cnt    <= '0;
      len_q       <= LEN_ONE;
      burst_cnt_a <= '0;
      burst_cnt_b <= '0;
    end else if (state == IDLE) begin
      if (state_nxt != IDLE) begin
        len_q    <= (burst_len == '0) ? LEN_ONE : burst_len;
        beat_cnt <= '0;
      end
    end else if (beat_done) begin
      if (last_beat) begin
        beat_cnt <= '0;
        ptr      <= (state == GRANT_A);
        if (state == GRANT_A) burst_cnt_a <= burst_cnt_a + CNT_WIDTH'(1);
        else                  burst_cnt_b <= burst_cnt_b + CNT_WIDTH'(1);
      end else begin
        beat_cnt <= beat_cnt + LEN_ONE;
      end
    end
  end

endmodule
